// File: rtl/alu_exec_stage_pkg.sv
// Shared opcode set, flag bit positions and command/result record types for
// the ALU and its registered execute stage.
package alu_ops;

    localparam int ALU_WIDTH = 4;

    typedef enum logic [3:0] {
        ADD_OP      = 4'd0,
        SUB_OP      = 4'd1,
        AND_OP      = 4'd2,
        OR_OP       = 4'd3,
        XOR_OP      = 4'd4,
        NOT_OP      = 4'd5,
        LL_SHIFT_OP = 4'd6,
        LR_SHIFT_OP = 4'd7,
        AR_SHIFT_OP = 4'd8
    } alu_op_e;

    // Bit positions inside the {N, Z, C, V} flag word
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic [3:0]           opcode;
        logic [ALU_WIDTH-1:0] a;
        logic [ALU_WIDTH-1:0] b;
        logic                 use_carry;
    } alu_cmd_t;

    typedef struct packed {
        logic [ALU_WIDTH-1:0] y;
        logic [3:0]           flags;
    } alu_res_t;

    function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                              input logic c, input logic v);
        logic [3:0] f;
        f         = '0;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/alu_exec_stage_if.sv
// Command and result handshakes of the execute stage. The stage itself is
// the slave; the producer/consumer side (or a bench) is the master.
interface alu_exec_stage_if #(parameter int WIDTH = 4);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_opcode;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_use_carry;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic [3:0]       out_flags;

    modport slave (
        input  in_valid, in_opcode, in_a, in_b, in_use_carry, out_ready,
        output in_ready, out_valid, out_y, out_flags
    );

    modport master (
        output in_valid, in_opcode, in_a, in_b, in_use_carry, out_ready,
        input  in_ready, out_valid, out_y, out_flags
    );
endinterface

// File: rtl/alu_exec_stage_alu.sv
// Combinational ALU. Carry and overflow are only meaningful for add/sub;
// every other opcode reports C=0 and V=0. Unknown opcodes yield zero.
module alu
    import alu_ops::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] y,
    output logic             negative,
    output logic             zero,
    output logic             cout,
    output logic             overflow
);

    logic [WIDTH:0] sum;

    // Result, carry-out and overflow selected by opcode
    always_comb begin
        sum      = '0;
        y        = '0;
        cout     = 1'b0;
        overflow = 1'b0;
        case (opcode)
            ADD_OP: begin
                sum      = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
                y        = sum[WIDTH-1:0];
                cout     = sum[WIDTH];
                overflow = (a[WIDTH-1] == b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
            end
            SUB_OP: begin
                // Two's complement subtract; carry set means no borrow
                sum      = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
                y        = sum[WIDTH-1:0];
                cout     = sum[WIDTH];
                overflow = (a[WIDTH-1] != b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
            end
            AND_OP:      y = a & b;
            OR_OP:       y = a | b;
            XOR_OP:      y = a ^ b;
            NOT_OP:      y = ~a;
            LL_SHIFT_OP: y = a << b;
            LR_SHIFT_OP: y = a >> b;
            AR_SHIFT_OP: y = $signed(a) >>> b;
            default:     y = '0;
        endcase
        negative = y[WIDTH-1];
        zero     = (y == '0);
    end

endmodule

// File: rtl/alu_exec_stage.sv
// Two-deep in-order execute stage: S1 holds the pending command, S2 the
// registered result. A stored C flag lets the next command chain its
// carry-in without stalling, since it updates exactly when an op leaves S1.
module alu_exec_stage
    import alu_ops::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    alu_exec_stage_if.slave   bus,
    output logic              carry_flag
);

    alu_cmd_t         cmd_reg, cmd_next;
    logic             s1_valid_reg, s1_valid_next;
    alu_res_t         res_reg, res_next;
    logic             s2_valid_reg, s2_valid_next;
    logic             carry_reg, carry_next;

    logic             s2_free;
    logic             s1_adv;
    logic             in_ready;
    logic             alu_cin;
    logic [WIDTH-1:0] alu_y;
    logic             alu_n, alu_z, alu_c, alu_v;

    // Advance conditions: S2 empties or drains, S1 moves on, S1 can refill
    always_comb begin
        s2_free  = !s2_valid_reg || bus.out_ready;
        s1_adv   = s1_valid_reg && s2_free;
        in_ready = !s1_valid_reg || s1_adv;
        alu_cin  = cmd_reg.use_carry && carry_reg;
    end

    alu #(.WIDTH(WIDTH)) u_alu (
        .opcode   (cmd_reg.opcode),
        .a        (cmd_reg.a),
        .b        (cmd_reg.b),
        .cin      (alu_cin),
        .y        (alu_y),
        .negative (alu_n),
        .zero     (alu_z),
        .cout     (alu_c),
        .overflow (alu_v)
    );

    // Next state of both pipeline stages and the stored carry
    always_comb begin
        cmd_next      = cmd_reg;
        s1_valid_next = s1_valid_reg;
        res_next      = res_reg;
        s2_valid_next = s2_valid_reg;
        carry_next    = carry_reg;

        if (bus.in_valid && in_ready) begin
            cmd_next.opcode    = bus.in_opcode;
            cmd_next.a         = bus.in_a;
            cmd_next.b         = bus.in_b;
            cmd_next.use_carry = bus.in_use_carry;
            s1_valid_next      = 1'b1;
        end else if (s1_adv) begin
            s1_valid_next = 1'b0;
        end

        if (s1_adv) begin
            res_next.y     = alu_y;
            res_next.flags = pack_flags(alu_n, alu_z, alu_c, alu_v);
            s2_valid_next  = 1'b1;
            carry_next     = alu_c;
        end else if (s2_valid_reg && bus.out_ready) begin
            s2_valid_next = 1'b0;
        end
    end

    // State registers; reset wins over any concurrent handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_reg      <= '0;
            s1_valid_reg <= 1'b0;
            res_reg      <= '0;
            s2_valid_reg <= 1'b0;
            carry_reg    <= 1'b0;
        end else begin
            cmd_reg      <= cmd_next;
            s1_valid_reg <= s1_valid_next;
            res_reg      <= res_next;
            s2_valid_reg <= s2_valid_next;
            carry_reg    <= carry_next;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = s2_valid_reg;
    assign bus.out_y     = res_reg.y;
    assign bus.out_flags = res_reg.flags;
    assign carry_flag    = carry_reg;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: inputs change on the falling edge and
// outputs are sampled on the falling edge, away from the active rising edge.
module tb_alu_exec_stage;
    import alu_ops::*;

    logic clk = 1'b0;
    logic reset;
    logic carry_flag;
    int   n_cmp = 0;
    int   n_err = 0;

    alu_exec_stage_if #(.WIDTH(4)) bus ();

    alu_exec_stage #(.WIDTH(4)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.slave),
        .carry_flag (carry_flag)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic drive_cmd(input logic [3:0] op, input logic [3:0] a,
                             input logic [3:0] b, input logic uc);
        bus.in_valid     = 1'b1;
        bus.in_opcode    = op;
        bus.in_a         = a;
        bus.in_b         = b;
        bus.in_use_carry = uc;
    endtask

    task automatic idle();
        bus.in_valid     = 1'b0;
        bus.in_opcode    = 4'h0;
        bus.in_a         = 4'h0;
        bus.in_b         = 4'h0;
        bus.in_use_carry = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic [3:0] y, input logic [3:0] f);
        check_val({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check_val({tag, "_y"},     32'(bus.out_y),     32'(y));
        check_val({tag, "_flags"}, 32'(bus.out_flags), 32'(f));
    endtask

    initial begin
        reset         = 1'b1;
        bus.out_ready = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state
        check_val("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_val("rst_out_y",     32'(bus.out_y),     32'd0);
        check_val("rst_out_flags", 32'(bus.out_flags), 32'd0);
        check_val("rst_carry",     32'(carry_flag),    32'd0);

        // Single LL shift: 0001 << 1 = 0010, one-cycle valid pulse
        bus.out_ready = 1'b1;
        drive_cmd(LL_SHIFT_OP, 4'b0001, 4'b0001, 1'b0);
        @(negedge clk); idle();
        check_val("lsl_early_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check_out("lsl", 4'b0010, 4'b0000);
        @(negedge clk);
        check_val("lsl_pulse_end", 32'(bus.out_valid), 32'd0);

        // Back-to-back NOT then XOR
        drive_cmd(NOT_OP, 4'b1000, 4'b0000, 1'b0);
        @(negedge clk); drive_cmd(XOR_OP, 4'b1010, 4'b1010, 1'b0);
        @(negedge clk); idle();
        check_out("not", 4'b0111, 4'b0000);
        @(negedge clk);
        check_out("xor", 4'b0000, 4'b0100);
        @(negedge clk);
        check_val("b2b_end_valid", 32'(bus.out_valid), 32'd0);

        // Backpressure: three commands with the consumer stalled
        bus.out_ready = 1'b0;
        drive_cmd(AND_OP, 4'b1111, 4'b0111, 1'b0);
        @(negedge clk);
        check_val("bp_ready_2nd", 32'(bus.in_ready), 32'd1);
        drive_cmd(OR_OP, 4'b1000, 4'b0100, 1'b0);
        @(negedge clk);
        drive_cmd(AR_SHIFT_OP, 4'b1001, 4'b0001, 1'b0);
        check_val("bp_full_ready", 32'(bus.in_ready), 32'd0);
        check_out("bp_and_held", 4'b0111, 4'b0000);
        @(negedge clk);
        check_val("bp_still_full", 32'(bus.in_ready), 32'd0);
        check_out("bp_and_stable", 4'b0111, 4'b0000);
        bus.out_ready = 1'b1;
        #1;
        check_val("bp_ready_comb", 32'(bus.in_ready), 32'd1);
        @(negedge clk); idle();
        check_out("bp_or", 4'b1100, 4'b1000);
        @(negedge clk);
        check_out("bp_asr", 4'b1100, 4'b1000);
        @(negedge clk);
        check_val("bp_drained", 32'(bus.out_valid), 32'd0);

        // Carry chain: C set, chained in, set again, then forced off
        drive_cmd(ADD_OP, 4'b1111, 4'b0001, 1'b0);
        @(negedge clk); drive_cmd(ADD_OP, 4'b0001, 4'b0001, 1'b1);
        check_val("cc_early_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk); drive_cmd(ADD_OP, 4'b1000, 4'b1000, 1'b0);
        check_out("cc_add1", 4'b0000, 4'b0110);
        check_val("cc_carry1", 32'(carry_flag), 32'd1);
        check_val("cc_cin_chain", 32'(u_dut.u_alu.cin), 32'd1);
        @(negedge clk); drive_cmd(ADD_OP, 4'b0001, 4'b0001, 1'b0);
        check_out("cc_adc", 4'b0011, 4'b0000);
        check_val("cc_carry2", 32'(carry_flag), 32'd0);
        @(negedge clk); idle();
        check_out("cc_add_ovf", 4'b0000, 4'b0111);
        check_val("cc_carry3", 32'(carry_flag), 32'd1);
        check_val("cc_cin_forced0", 32'(u_dut.u_alu.cin), 32'd0);
        @(negedge clk);
        check_out("cc_add_nc", 4'b0010, 4'b0000);
        check_val("cc_carry4", 32'(carry_flag), 32'd0);

        // Unlisted opcode: ALU yields zero
        drive_cmd(4'hF, 4'b1010, 4'b0101, 1'b0);
        @(negedge clk); idle();
        @(negedge clk);
        check_out("unlisted", 4'b0000, 4'b0100);
        @(negedge clk);

        // Reset with both stages full, handshake offered during reset
        bus.out_ready = 1'b0;
        drive_cmd(ADD_OP, 4'b1111, 4'b0001, 1'b0);
        @(negedge clk); drive_cmd(XOR_OP, 4'b0110, 4'b0011, 1'b0);
        @(negedge clk); idle();
        check_val("mr_full_ready", 32'(bus.in_ready), 32'd0);
        check_val("mr_carry_set",  32'(carry_flag),   32'd1);
        reset         = 1'b1;
        bus.out_ready = 1'b1;
        drive_cmd(OR_OP, 4'b0001, 4'b0010, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        idle();
        check_val("mr_out_valid", 32'(bus.out_valid), 32'd0);
        check_val("mr_in_ready",  32'(bus.in_ready),  32'd1);
        check_val("mr_out_flags", 32'(bus.out_flags), 32'd0);
        check_val("mr_out_y",     32'(bus.out_y),     32'd0);
        check_val("mr_carry",     32'(carry_flag),    32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val($sformatf("mr_no_ghost%0d", i), 32'(bus.out_valid), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_exec_stage.md
# alu_exec_stage

Registered execute stage wrapped around the existing combinational `alu`. It accepts operation commands through a valid/ready handshake and latches them into an operand register. It evaluates them with one `alu` instance and delivers the result plus a registered NZCV flag word through a second valid/ready handshake to the writeback consumer. The stage is a two-deep, fully pipelined, in-order buffer with a persistent carry flag that can feed the next operation's carry-in.

## Interface
- `WIDTH`, 4, datapath width; passed unchanged to the `alu` instance
- `clk`  in  1  single clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high; clears all state at the next rising edge
- `in_valid`  in  1  command present
- `in_ready`  out  1  stage can accept a command this cycle
- `in_opcode`  in  4  `alu_ops` opcode
- `in_a`, `in_b`  in  WIDTH  operands (`in_b` is the shift amount for shift ops)
- `in_use_carry`  in  1  1: ALU `cin` = stored C flag; 0: `cin` = 0
- `out_valid`  out  1  result present
- `out_ready`  in  1  consumer takes the result this cycle
- `out_y`  out  WIDTH  result
- `out_flags`  out  4  {N, Z, C, V} belonging to `out_y`
- `carry_flag`  out  1  current stored C flag (debug/status)

## Operation
- **Stage 1 (S1):** command register {opcode, a, b, use_carry, valid}.
- **Stage 2 (S2):** result register {y, N, Z, C, V, valid}.
- **Advance signals:**
  - `s2_free = !s2_valid || out_ready`
  - `s1_adv = s1_valid && s2_free`
  - `in_ready = !s1_valid || s1_adv`
- **Accept:** `in_valid && in_ready` loads S1 and sets `s1_valid`. Otherwise S1 is cleared when it advances, or held.
- **ALU evaluation:** the ALU is driven only from S1. On `s1_adv`:
  - S2 captures `y`, `negative`, `zero`, `cout`, `overflow`.
  - The stored C flag ← `cout` at the same edge.
- **Carry chaining:** a dependent op in S1 always sees the carry of the immediately preceding op, with no stall and no hazard. The carry register updates only on `s1_adv`, and ops advance strictly in order.
- **S2 transfer:** `out_valid && out_ready` transfers the result. S2 reloads from S1 in the same cycle if `s1_adv`, otherwise `s2_valid` clears.
- **Flag semantics:** exactly as the `alu` outputs them. The stage does not reinterpret flags per opcode.
- **Unlisted opcodes:** passed through unchanged; the result is whatever `alu` produces.
- **Reset values:** `in_ready` = 1, `out_valid` = 0, `out_y` = 0, `out_flags` = 0, `carry_flag` = 0. S1 contents are cleared.

## Timing
- Latency: a command accepted at edge k appears on `out_y` with `out_valid`=1 after edge k+1. This is 2 cycles from `in_valid` being sampled to the result being visible.
- Throughput: 1 op/cycle while `out_ready`=1.
- Full condition (S1 and S2 valid, `out_ready`=0): `in_ready`=0. `in_ready` is combinational from `out_ready`.
- Simultaneous accept + S1 advance + S2 transfer in one cycle is legal and loses no command.
- `out_y`/`out_flags` are stable while `out_valid`=1 and `out_ready`=0.
- `in_*` payload is ignored when `in_ready`=0 or `in_valid`=0.
- Reset mid-operation: in-flight commands are discarded and no `out_valid` pulse follows. `reset` dominates a concurrent handshake.

## Structure
- Opcodes stay in `alu_ops`.
- Add the following to `alu_ops`:
  - `FLAG_N`, `FLAG_Z`, `FLAG_C`, `FLAG_V` bit indices for `out_flags`
  - packed struct `alu_cmd_t` {opcode, a, b, use_carry}
  - packed struct `alu_res_t` {y, flags}
- One sub-module: the existing `alu` instance `u_alu`. No other hierarchy.

## Test plan
- `LL_SHIFT_OP` a=0001 b=0001 with `out_ready`=1 → two cycles later `out_y`=0010, `out_flags`=0000 (N=0, Z=0), single `out_valid` pulse.
- Back-to-back `NOT_OP` a=1000, then `XOR_OP` a=1010 b=1010 → consecutive results 0111 (N=0, Z=0), then 0000 (Z=1).
- `out_ready`=0, issue three commands (`AND_OP` 1111&0111, `OR_OP` 1000|0100, `AR_SHIFT_OP` 1001>>1):
  - `in_ready` drops after two accepts; the third command is held.
  - Raise `out_ready`: results come out in order 0111, 1100, 1100 with no loss and no duplication.
- Carry chain: an op whose `alu` `cout`=1 followed immediately by an op with `in_use_carry`=1:
  - ALU `cin`=1 during the second op.
  - `carry_flag` equals the ALU `cout` after each advance.
  - `in_use_carry`=0 forces `cin`=0.
- Reset mid-stream with S1 and S2 full → next cycle `out_valid`=0, `in_ready`=1, `out_flags`=0, `carry_flag`=0. The old commands never appear.
